// File: rtl/disp_pkg.sv
// Shared constants and types for the four-digit multiplexed display scanner.
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Active-low one-hot anode pattern for the given digit.
    function automatic logic [NUM_DIGITS-1:0] an_select(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running 0..DIV-1 counter; TICK marks the terminal count, CNT_ZERO the first count.
module scan_prescaler #(
    parameter int unsigned DIV = 50000
) (
    input  logic CLK,
    input  logic RESET,
    output logic TICK,
    output logic CNT_ZERO
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign TICK     = (cnt == LAST);
    assign CNT_ZERO = (cnt == '0);

endmodule

// File: rtl/disp_scan.sv
// Four-digit 7-segment scan multiplexer with registered HEX/AN/SCAN_TICK outputs.
// Optional leading-zero blanking: compile with `define DISP_SCAN_LZB_EN.
module disp_scan
    import disp_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] DIGITS,
    input  logic        LOAD,
    input  logic        ENABLE,
    output logic [3:0]  HEX,
    output logic [3:0]  AN,
    output logic        SCAN_TICK
);

    logic [15:0]           shadow;
    digit_idx_t            idx;
    logic                  tick;
    logic                  cnt_zero;
    logic [NUM_DIGITS-1:0] blank;

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .CLK      (CLK),
        .RESET    (RESET),
        .TICK     (tick),
        .CNT_ZERO (cnt_zero)
    );

`ifdef DISP_SCAN_LZB_EN
    // Digit i is blanked when it and every more significant digit are zero.
    always_comb begin
        blank    = '0;
        blank[1] = (shadow[15:4]  == '0);
        blank[2] = (shadow[15:8]  == '0);
        blank[3] = (shadow[15:12] == '0);
    end
`else
    assign blank = '0;
`endif

    // Outputs are a one-cycle-delayed view of prescaler/index/shadow, so the
    // AN guard lands exactly on the cycle where HEX switches digit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shadow    <= '0;
            idx       <= '0;
            HEX       <= '0;
            AN        <= AN_OFF;
            SCAN_TICK <= 1'b0;
        end else begin
            if (LOAD) begin
                shadow <= DIGITS;
            end
            if (tick) begin
                idx <= idx + 2'd1;
            end
            HEX       <= shadow[{idx, 2'b00} +: 4];
            SCAN_TICK <= tick;
            if (cnt_zero || !ENABLE || blank[idx]) begin
                AN <= AN_OFF;
            end else begin
                AN <= an_select(idx);
            end
        end
    end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 SHALL have parameter DIV, default 50000, scan prescaler terminal count in CLK cycles per digit, legal range 2..65535.
REQ-002 SHALL have port CLK  input  1  single system clock, all state rising-edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port DIGITS  input  16  four hex nibbles; [3:0] digit0 (rightmost) .. [15:12] digit3.
REQ-005 SHALL have port LOAD  input  1  capture DIGITS into shadow register on this edge.
REQ-006 SHALL have port ENABLE  input  1  display on; low forces all anodes off.
REQ-007 SHALL have port HEX  output  4  nibble of currently selected digit, feeds the 7-segment decoder.
REQ-008 SHALL have port AN  output  4  active-low one-hot anode enables, AN[i] selects digit i.
REQ-009 SHALL have port SCAN_TICK  output  1  one-cycle pulse at each digit advance.

Function
REQ-010 SHALL hold a 16-bit shadow register, written from DIGITS on every edge with LOAD=1; DIGITS ignored when LOAD=0.
REQ-011 SHALL run a prescaler counting 0..DIV-1 and wrapping to 0; terminal count (DIV-1) is a tick.
REQ-012 SHALL advance a 2-bit digit index 0->1->2->3->0 on each tick; index wraps 3->0 without gap.
REQ-013 SHALL register all outputs; HEX, AN, SCAN_TICK change on the edge after the tick/index change (latency 1 cycle).
REQ-014 SHALL drive HEX = shadow nibble selected by the index, regardless of ENABLE.
REQ-015 SHALL drive AN = all ones (4'b1111) in the cycle where prescaler = 0 (ghosting guard), else one-hot low at the index.
REQ-016 SHALL drive AN = 4'b1111 whenever ENABLE=0; prescaler, index and HEX keep running.
REQ-017 SHALL pulse SCAN_TICK high for exactly one cycle per tick, independent of ENABLE.
REQ-018 SHALL, when LOAD coincides with a tick, use the new shadow value from the following output update onward; no stale or mixed nibble.
REQ-019 SHALL never drive more than one AN bit low in any cycle.

Reset
REQ-020 SHALL, on RESET high, immediately clear prescaler, index, shadow to 0; AN=4'b1111, HEX=4'h0, SCAN_TICK=0.
REQ-021 SHALL, on RESET mid-scan, abandon the current digit; after release, first tick occurs DIV cycles later on digit 0 -> 1.
REQ-022 SHALL release reset deassertion-synchronously to CLK by the integrator; block itself treats RESET as pure async clear.

Configuration
REQ-023 SHALL support macro DISP_SCAN_LZB_EN (leading-zero blanking).
REQ-024 SHALL, with DISP_SCAN_LZB_EN defined, hold AN[i] high for i in 3..1 when shadow digit i and all higher digits are zero; digit0 never blanked.
REQ-025 SHALL, without DISP_SCAN_LZB_EN, display all four digits including leading zeros; no extra logic synthesised.

Structure
REQ-026 SHALL take NUM_DIGITS=4, AN_OFF=4'b1111 and the 2-bit digit-index typedef from shared package disp_pkg.
REQ-027 SHALL implement the prescaler as sub-module scan_prescaler (params DIV; ports CLK, RESET, TICK, CNT_ZERO).

Verification (DIV=4)
REQ-028 SHALL check reset: RESET pulse mid-scan -> AN=4'b1111, HEX=0 same cycle; first SCAN_TICK 4 cycles after release.
REQ-029 SHALL check scan: LOAD DIGITS=16'h1234, ENABLE=1 -> HEX sequence 4,3,2,1 repeating, AN 1110,1101,1011,0111, each with 1-cycle 1111 guard, period 16 cycles.
REQ-030 SHALL check blank: ENABLE=0 for 10 cycles -> AN=1111 throughout, SCAN_TICK still every 4 cycles, HEX continues sequence.
REQ-031 SHALL check LOAD/tick collision: LOAD 16'hABCD on tick edge -> next HEX value from new shadow, never old/new mix.
REQ-032 SHALL check LZB (macro on): DIGITS=16'h0050 -> AN[3],AN[2] never low, digits 1,0 show 5,0; DIGITS=16'h0000 -> only digit0 lit showing 0; macro off -> all four anodes cycle.
REQ-033 SHALL assert continuously: AN has at most one zero bit; SCAN_TICK never high two consecutive cycles.
